// File: rtl/pong_physics.sv
// Pong game-state engine: once per video frame it advances the ball, the paddles,
// the scores and the serve / play / game-over control. All outputs are registered.
module pong_physics #(
   parameter int BALL_SIZE    = 8,
   parameter int BALL_SPEED   = 2,
   parameter int PADDLE_W     = 8,
   parameter int PADDLE_H     = 64,
   parameter int PADDLE_SPEED = 4,
   parameter int P1_X         = 16,
   parameter int P2_X         = 616,
   parameter int SERVE_FRAMES = 60,
   parameter int WIN_SCORE    = 7
) (
   input  logic       clk50M,
   input  logic       reset,
   input  logic       endofframe,
   input  logic       p1_up,
   input  logic       p1_down,
   input  logic       p2_up,
   input  logic       p2_down,
   input  logic       start,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [9:0] paddle_one_x,
   output logic [9:0] paddle_one_y,
   output logic [9:0] paddle_two_x,
   output logic [9:0] paddle_two_y,
   output logic [3:0] score_one,
   output logic [3:0] score_two,
   output logic       game_over
);
   localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

   localparam logic [9:0]  BALL_CX     = 10'(320 - BALL_SIZE / 2);
   localparam logic [9:0]  BALL_CY     = 10'(240 - BALL_SIZE / 2);
   localparam logic [9:0]  PAD_Y0      = 10'(240 - PADDLE_H / 2);
   localparam logic [9:0]  PAD_Y_MAX   = 10'(480 - PADDLE_H);
   localparam logic [9:0]  PAD_SPD     = 10'(PADDLE_SPEED);
   localparam logic [9:0]  BALL_SPD    = 10'(BALL_SPEED);
   localparam logic [9:0]  BALL_Y_MAX  = 10'(480 - BALL_SIZE);
   localparam logic [9:0]  HIT1_X      = 10'(P1_X + PADDLE_W);
   localparam logic [9:0]  HIT2_X      = 10'(P2_X - BALL_SIZE);
   localparam logic [10:0] SPD11       = 11'(BALL_SPEED);
   localparam logic [10:0] SIZE11      = 11'(BALL_SIZE);
   localparam logic [10:0] PADH11      = 11'(PADDLE_H);
   localparam logic [10:0] P1_FACE     = 11'(P1_X + PADDLE_W);
   localparam logic [10:0] P2_FACE     = 11'(P2_X);
   localparam logic [10:0] BALL_X_MAX  = 11'(640 - BALL_SIZE);
   localparam logic [10:0] BALL_Y_MAX11 = 11'(480 - BALL_SIZE);
   localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
   localparam logic [3:0]  WIN         = 4'(WIN_SCORE);

   typedef enum logic [1:0] {S_SERVE, S_PLAY, S_OVER} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [9:0]       bx_q, bx_d, by_q, by_d;
   logic [9:0]       p1y_q, p1y_d, p2y_q, p2y_d;
   logic [3:0]       s1_q, s1_d, s2_q, s2_d;
   logic             dx_q, dx_d, dy_q, dy_d;
   logic             go_q, go_d;
   logic             eof_q, eof_d;

   logic             tick;
   logic             miss_l, miss_r;
   logic [10:0]      bx11, by11;
   logic [9:0]       p1_new, p2_new;
   logic [3:0]       score_new;

   function automatic logic [9:0] paddle_step(input logic [9:0] y, input logic up,
                                              input logic dn);
      logic [9:0] r;
      r = y;
      if (up && !dn)      r = (y < PAD_SPD) ? 10'd0 : y - PAD_SPD;
      else if (dn && !up) r = (y > PAD_Y_MAX - PAD_SPD) ? PAD_Y_MAX : y + PAD_SPD;
      return r;
   endfunction

   function automatic logic overlaps(input logic [9:0] by, input logic [9:0] py);
      logic [10:0] b, p;
      b = {1'b0, by};
      p = {1'b0, py};
      return (b + SIZE11 > p) && (b < p + PADH11);
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bx_d      = bx_q;
      by_d      = by_q;
      p1y_d     = p1y_q;
      p2y_d     = p2y_q;
      s1_d      = s1_q;
      s2_d      = s2_q;
      dx_d      = dx_q;
      dy_d      = dy_q;
      go_d      = go_q;
      eof_d     = endofframe;
      tick      = endofframe & ~eof_q;
      miss_l    = 1'b0;
      miss_r    = 1'b0;
      score_new = 4'd0;
      bx11      = {1'b0, bx_q};
      by11      = {1'b0, by_q};
      p1_new    = paddle_step(p1y_q, p1_up, p1_down);
      p2_new    = paddle_step(p2y_q, p2_up, p2_down);

      if (tick) begin
         case (state_q)
            S_SERVE: begin
               p1y_d = p1_new;
               p2y_d = p2_new;
               if (cnt_q == SERVE_LAST) begin
                  cnt_d   = '0;
                  state_d = S_PLAY;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_PLAY: begin
               p1y_d = p1_new;
               p2y_d = p2_new;
               if (!dy_q) begin
                  if (by_q < BALL_SPD) begin
                     by_d = 10'd0;
                     dy_d = 1'b1;
                  end else begin
                     by_d = by_q - BALL_SPD;
                  end
               end else if (by11 + SPD11 > BALL_Y_MAX11) begin
                  by_d = BALL_Y_MAX;
                  dy_d = 1'b0;
               end else begin
                  by_d = by_q + BALL_SPD;
               end
               // Paddle faces are tested against pre-move paddle positions.
               if (!dx_q) begin
                  if (bx11 >= P1_FACE && bx11 <= P1_FACE + SPD11 && overlaps(by_q, p1y_q)) begin
                     bx_d = HIT1_X;
                     dx_d = 1'b1;
                  end else if (bx11 < SPD11) begin
                     miss_l = 1'b1;
                  end else begin
                     bx_d = bx_q - BALL_SPD;
                  end
               end else begin
                  if (bx11 + SIZE11 <= P2_FACE && bx11 + SIZE11 + SPD11 >= P2_FACE &&
                      overlaps(by_q, p2y_q)) begin
                     bx_d = HIT2_X;
                     dx_d = 1'b0;
                  end else if (bx11 + SPD11 > BALL_X_MAX) begin
                     miss_r = 1'b1;
                  end else begin
                     bx_d = bx_q + BALL_SPD;
                  end
               end
               if (miss_l || miss_r) begin
                  bx_d      = BALL_CX;
                  by_d      = BALL_CY;
                  dy_d      = dy_q;
                  dx_d      = miss_r;
                  score_new = miss_l ? s2_q + 4'd1 : s1_q + 4'd1;
                  if (miss_l) s2_d = score_new;
                  else        s1_d = score_new;
                  if (score_new == WIN) begin
                     state_d = S_OVER;
                     go_d    = 1'b1;
                  end else begin
                     state_d = S_SERVE;
                     cnt_d   = '0;
                  end
               end
            end
            S_OVER: begin
               if (start) begin
                  s1_d    = 4'd0;
                  s2_d    = 4'd0;
                  p1y_d   = PAD_Y0;
                  p2y_d   = PAD_Y0;
                  dx_d    = 1'b1;
                  cnt_d   = '0;
                  go_d    = 1'b0;
                  state_d = S_SERVE;
               end
            end
            default: state_d = S_SERVE;
         endcase
      end
   end

   always_ff @(posedge clk50M) begin
      if (reset) begin
         state_q <= S_SERVE;
         cnt_q   <= '0;
         bx_q    <= BALL_CX;
         by_q    <= BALL_CY;
         p1y_q   <= PAD_Y0;
         p2y_q   <= PAD_Y0;
         s1_q    <= 4'd0;
         s2_q    <= 4'd0;
         dx_q    <= 1'b1;
         dy_q    <= 1'b1;
         go_q    <= 1'b0;
         eof_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bx_q    <= bx_d;
         by_q    <= by_d;
         p1y_q   <= p1y_d;
         p2y_q   <= p2y_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         go_q    <= go_d;
         eof_q   <= eof_d;
      end
   end

   assign ball_x       = bx_q;
   assign ball_y       = by_q;
   assign paddle_one_x = 10'(P1_X);
   assign paddle_one_y = p1y_q;
   assign paddle_two_x = 10'(P2_X);
   assign paddle_two_y = p2y_q;
   assign score_one    = s1_q;
   assign score_two    = s2_q;
   assign game_over    = go_q;

endmodule

// File: tb/tb_pong_physics.sv
// Self-checking bench for pong_physics: a frame-level game model in plain integer
// arithmetic predicts every output; scenario tasks drive buttons and frame pulses.
module tb_pong_physics;
   logic       clk50M = 1'b0;
   logic       reset, endofframe, p1_up, p1_down, p2_up, p2_down, start;
   logic [9:0] ball_x, ball_y, paddle_one_x, paddle_one_y, paddle_two_x, paddle_two_y;
   logic [3:0] score_one, score_two;
   logic       game_over;

   always #5 clk50M = ~clk50M;

   pong_physics dut (
      .clk50M(clk50M), .reset(reset), .endofframe(endofframe),
      .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
      .start(start),
      .ball_x(ball_x), .ball_y(ball_y),
      .paddle_one_x(paddle_one_x), .paddle_one_y(paddle_one_y),
      .paddle_two_x(paddle_two_x), .paddle_two_y(paddle_two_y),
      .score_one(score_one), .score_two(score_two), .game_over(game_over)
   );

   int errors = 0;
   int checks = 0;

   // Model state: phase 0 = serving, 1 = in play, 2 = game over; directions are +1/-1.
   int m_bx, m_by, m_p1, m_p2, m_s1, m_s2, m_dx, m_dy, m_phase, m_cnt;
   bit m_prev;

   function automatic logic [68:0] dut_vec();
      return {ball_x, ball_y, paddle_one_x, paddle_one_y, paddle_two_x, paddle_two_y,
              score_one, score_two, game_over};
   endfunction

   function automatic logic [68:0] mdl_vec();
      return {10'(m_bx), 10'(m_by), 10'd16, 10'(m_p1), 10'd616, 10'(m_p2),
              4'(m_s1), 4'(m_s2), (m_phase == 2)};
   endfunction

   function automatic int pad_move(input int y, input bit up, input bit dn);
      int r;
      r = y;
      if (up && !dn) r = (y - 4 < 0) ? 0 : y - 4;
      if (dn && !up) r = (y + 4 > 416) ? 416 : y + 4;
      return r;
   endfunction

   task automatic model_reset();
      m_bx = 316; m_by = 236; m_p1 = 208; m_p2 = 208;
      m_s1 = 0; m_s2 = 0; m_dx = 1; m_dy = 1; m_phase = 0; m_cnt = 0; m_prev = 1'b1;
   endtask

   task automatic vstep(inout int y, inout int d);
      if (d < 0) begin
         if (y < 2) begin y = 0; d = 1; end
         else y = y - 2;
      end else begin
         if (y + 2 > 472) begin y = 472; d = -1; end
         else y = y + 2;
      end
   endtask

   task automatic model_step(input bit e, input bit [3:0] b, input bit st, input bit rst);
      int n1, n2, ob, od;
      bit tick, ml, mr;
      if (rst) begin
         model_reset();
         return;
      end
      tick   = e && !m_prev;
      m_prev = e;
      if (!tick) return;
      if (m_phase == 2) begin
         if (st) begin
            m_s1 = 0; m_s2 = 0; m_p1 = 208; m_p2 = 208; m_dx = 1; m_phase = 0; m_cnt = 0;
         end
         return;
      end
      n1 = pad_move(m_p1, b[3], b[2]);
      n2 = pad_move(m_p2, b[1], b[0]);
      if (m_phase == 0) begin
         m_p1 = n1; m_p2 = n2;
         if (m_cnt == 59) begin m_cnt = 0; m_phase = 1; end
         else m_cnt++;
         return;
      end
      ob = m_by; od = m_dy; ml = 1'b0; mr = 1'b0;
      vstep(m_by, m_dy);
      if (m_dx < 0) begin
         if (m_bx >= 24 && m_bx - 2 <= 24 && ob + 8 > m_p1 && ob < m_p1 + 64) begin
            m_bx = 24; m_dx = 1;
         end else if (m_bx < 2) ml = 1'b1;
         else m_bx = m_bx - 2;
      end else begin
         if (m_bx + 8 <= 616 && m_bx + 10 >= 616 && ob + 8 > m_p2 && ob < m_p2 + 64) begin
            m_bx = 608; m_dx = -1;
         end else if (m_bx + 2 > 632) mr = 1'b1;
         else m_bx = m_bx + 2;
      end
      m_p1 = n1; m_p2 = n2;
      if (ml || mr) begin
         m_bx = 316; m_by = 236; m_dy = od;
         m_dx = mr ? 1 : -1;
         if (ml) m_s2++; else m_s1++;
         if (m_s1 == 7 || m_s2 == 7) m_phase = 2;
         else begin m_phase = 0; m_cnt = 0; end
      end
   endtask

   // Drive one cycle at a falling edge, advance the model, wait for the next falling edge.
   task automatic cyc(input bit e, input bit [3:0] b, input bit st, input bit rst);
      endofframe = e;
      {p1_up, p1_down, p2_up, p2_down} = b;
      start = st;
      reset = rst;
      model_step(e, b, st, rst);
      @(negedge clk50M);
   endtask

   task automatic frame(input bit [3:0] b, input bit st);
      cyc(1'b0, b, st, 1'b0);
      cyc(1'b0, b, st, 1'b0);
      cyc(1'b1, b, st, 1'b0);
      cyc(1'b1, b, st, 1'b0);
   endtask

   task automatic track(input int pad, output bit [1:0] ud);
      int diff;
      diff = (m_by + 4) - (pad + 32);
      ud = (diff > 3) ? 2'b01 : (diff < -3) ? 2'b10 : 2'b00;
   endtask

   // Park the paddle in the half of the field the ball will not be in when it arrives.
   task automatic avoid(input int pad, input bit left, output bit [1:0] ud);
      int y, d, k, tgt;
      ud = 2'b00;
      if (m_phase != 1 || (left ? m_dx > 0 : m_dx < 0)) return;
      k = left ? (m_bx - 26) / 2 : (606 - m_bx) / 2;
      if (k < 0) k = 0;
      y = m_by; d = m_dy;
      for (int i = 0; i < k; i++) vstep(y, d);
      tgt = (y + 4 < 240) ? 416 : 0;
      if (pad > tgt) ud = 2'b10;
      else if (pad < tgt) ud = 2'b01;
   endtask

   task automatic test_reset();
      cyc(1'b1, 4'b0000, 1'b0, 1'b1);
      cyc(1'b1, 4'b0000, 1'b0, 1'b1);
      checks++;
      if (ball_x !== 10'd316 || ball_y !== 10'd236 || paddle_one_x !== 10'd16 ||
          paddle_two_x !== 10'd616 || paddle_one_y !== 10'd208 || paddle_two_y !== 10'd208 ||
          score_one !== 4'd0 || score_two !== 4'd0 || game_over !== 1'b0)
         begin errors++; $display("FAIL reset_values: got %h", dut_vec()); end
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 4'b0100, 1'b0, 1'b0);
         checks++;
         if (paddle_one_y !== 10'd208)
            begin errors++; $display("FAIL no_tick_after_reset: p1y=%0d want 208", paddle_one_y); end
      end
      frame(4'b0100, 1'b0);
      checks++;
      if (ball_x !== 10'd316 || ball_y !== 10'd236 || paddle_one_y !== 10'd212 || game_over !== 1'b0)
         begin errors++; $display("FAIL first_tick: got %h want bx=316 by=236 p1y=212", dut_vec()); end
   endtask

   task automatic test_serve();
      for (int f = 2; f <= 60; f++) begin
         frame(4'b0000, 1'b0);
         checks++;
         if (dut_vec() !== mdl_vec())
            begin errors++; $display("FAIL serve_hold f=%0d: dut=%h model=%h", f, dut_vec(), mdl_vec()); end
      end
      checks++;
      if (ball_x !== 10'd316 || ball_y !== 10'd236)
         begin errors++; $display("FAIL serve_tick60: ball=(%0d,%0d) want (316,236)", ball_x, ball_y); end
      frame(4'b0000, 1'b0);
      checks++;
      if (ball_x !== 10'd318 || ball_y !== 10'd238)
         begin errors++; $display("FAIL serve_release: ball=(%0d,%0d) want (318,238)", ball_x, ball_y); end
   endtask

   task automatic test_paddle_clamp();
      for (int f = 0; f < 60; f++) begin
         frame(4'b1000, 1'b0);
         checks++;
         if (dut_vec() !== mdl_vec())
            begin errors++; $display("FAIL p1_up f=%0d: dut=%h model=%h", f, dut_vec(), mdl_vec()); end
      end
      checks++;
      if (paddle_one_y !== 10'd0)
         begin errors++; $display("FAIL p1_clamp_top: p1y=%0d want 0", paddle_one_y); end
      for (int f = 0; f < 3; f++) frame(4'b0011, 1'b0);
      checks++;
      if (paddle_two_y !== 10'd208)
         begin errors++; $display("FAIL p2_both_pressed: p2y=%0d want 208", paddle_two_y); end
      for (int f = 0; f < 60; f++) begin
         frame(4'b0001, 1'b0);
         checks++;
         if (dut_vec() !== mdl_vec())
            begin errors++; $display("FAIL p2_down f=%0d: dut=%h model=%h", f, dut_vec(), mdl_vec()); end
      end
      checks++;
      if (paddle_two_y !== 10'd416)
         begin errors++; $display("FAIL p2_clamp_bottom: p2y=%0d want 416", paddle_two_y); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 4000; c++) begin
         cyc(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 1499) == 0));
         checks++;
         if (dut_vec() !== mdl_vec())
            begin errors++; $display("FAIL random c=%0d: dut=%h model=%h", c, dut_vec(), mdl_vec()); end
      end
   endtask

   task automatic test_left_miss();
      bit [1:0] a1, t2;
      cyc(1'b0, 4'b0000, 1'b0, 1'b1);
      cyc(1'b0, 4'b0000, 1'b0, 1'b0);
      for (int f = 0; f < 2000 && m_s2 == 0; f++) begin
         avoid(m_p1, 1'b1, a1);
         track(m_p2, t2);
         frame({a1, t2}, 1'b0);
         checks++;
         if (dut_vec() !== mdl_vec())
            begin errors++; $display("FAIL left_rally f=%0d: dut=%h model=%h", f, dut_vec(), mdl_vec()); end
      end
      checks++;
      if (m_s2 != 1) begin errors++; $display("FAIL left_miss_timeout: model score_two=%0d want 1", m_s2); end
      checks++;
      if (score_two !== 4'd1 || score_one !== 4'd0 || ball_x !== 10'd316 || ball_y !== 10'd236)
         begin errors++; $display("FAIL left_miss: s2=%0d s1=%0d ball=(%0d,%0d) want 1 0 (316,236)",
                                  score_two, score_one, ball_x, ball_y); end
      for (int f = 0; f < 61; f++) frame(4'b0000, 1'b0);
      checks++;
      if (ball_x !== 10'd314)
         begin errors++; $display("FAIL serve_toward_conceder: bx=%0d want 314", ball_x); end
   endtask

   task automatic test_game_over();
      bit [1:0] t1, a2;
      logic [68:0] frozen;
      cyc(1'b0, 4'b0000, 1'b0, 1'b1);
      cyc(1'b0, 4'b0000, 1'b0, 1'b0);
      for (int f = 0; f < 4000 && m_phase != 2; f++) begin
         track(m_p1, t1);
         avoid(m_p2, 1'b0, a2);
         frame({t1, a2}, 1'b0);
         checks++;
         if (dut_vec() !== mdl_vec())
            begin errors++; $display("FAIL game f=%0d: dut=%h model=%h", f, dut_vec(), mdl_vec()); end
      end
      checks++;
      if (m_phase != 2) begin errors++; $display("FAIL game_over_timeout: model phase=%0d want 2", m_phase); end
      checks++;
      if (game_over !== 1'b1 || score_one !== 4'd7 || ball_x !== 10'd316 || ball_y !== 10'd236)
         begin errors++; $display("FAIL game_over: go=%0d s1=%0d ball=(%0d,%0d) want 1 7 (316,236)",
                                  game_over, score_one, ball_x, ball_y); end
      frozen = mdl_vec();
      for (int f = 0; f < 5; f++) frame(4'($urandom), 1'b0);
      checks++;
      if (dut_vec() !== frozen)
         begin errors++; $display("FAIL over_frozen: dut=%h want %h", dut_vec(), frozen); end
      frame(4'b1001, 1'b1);
      checks++;
      if (score_one !== 4'd0 || score_two !== 4'd0 || game_over !== 1'b0 ||
          paddle_one_y !== 10'd208 || paddle_two_y !== 10'd208)
         begin errors++; $display("FAIL restart: got %h want scores 0 go 0 paddles 208", dut_vec()); end
      frame(4'b0000, 1'b0);
      checks++;
      if (dut_vec() !== mdl_vec() || ball_x !== 10'd316)
         begin errors++; $display("FAIL restart_serve: dut=%h model=%h", dut_vec(), mdl_vec()); end
   endtask

   initial begin
      reset = 1'b1; endofframe = 1'b1; start = 1'b0;
      p1_up = 1'b0; p1_down = 1'b0; p2_up = 1'b0; p2_down = 1'b0;
      model_reset();
      @(negedge clk50M);
      test_reset();
      test_serve();
      test_paddle_clamp();
      test_random();
      test_left_miss();
      test_game_over();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pong_physics.md
Name: pong_physics

Overview:
- Game-state engine that produces the ball and paddle coordinates the frame renderer consumes, and consumes the renderer's `endofframe` level.
- Advances the game exactly once per video frame: ball motion, wall and paddle bounces, paddle motion, scoring, serve and game-over control.
- Sits between the player button inputs and the graphics block.
- All outputs hold steady while a frame is scanned.

Parameters:
- BALL_SIZE, 8: ball square edge, pixels.
- BALL_SPEED, 2: ball displacement per frame on each axis, pixels.
- PADDLE_W, 8: paddle width, pixels.
- PADDLE_H, 64: paddle height, pixels.
- PADDLE_SPEED, 4: paddle displacement per frame, pixels.
- P1_X, 16: fixed left edge of paddle one.
- P2_X, 616: fixed left edge of paddle two.
- SERVE_FRAMES, 60: frames the ball is held at centre before play.
- WIN_SCORE, 7: score that ends the game.

Ports:
- clk50M  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- endofframe  in  1  high while the scan is in vertical blanking (synchronous to clk50M).
- p1_up, p1_down, p2_up, p2_down  in  1 each  debounced, synchronous button levels.
- start  in  1  level; restarts the game from GAME_OVER.
- ball_x, ball_y  out  10 each  ball top-left pixel (x 0..639, y 0..479).
- paddle_one_x, paddle_one_y  out  10 each  paddle one top-left pixel.
- paddle_two_x, paddle_two_y  out  10 each  paddle two top-left pixel.
- score_one, score_two  out  4 each  player scores.
- game_over  out  1  high in GAME_OVER state.

Behaviour:
- Clock and reset:
  - One clock, clk50M. reset is synchronous, active-high, and has priority over everything, including a simultaneous tick.
- Reset values:
  - ball_x=316, ball_y=236.
  - paddle_one_x=16, paddle_two_x=616 (constant thereafter); paddle_one_y=paddle_two_y=208.
  - Scores 0, game_over=0, state SERVE, serve counter 0.
  - dir_x=+ (toward paddle two), dir_y=+ (down).
  - endofframe delay register = 1, so a high endofframe at reset release does not produce a tick.
- Tick:
  - tick = endofframe & ~endofframe_d, a one-cycle pulse.
  - All state and outputs update only on tick cycles; outputs are registered and change the cycle after the tick.
  - Exactly one update per frame.
- State SERVE:
  - Ball held at (316,236); paddles move; counter increments per tick.
  - On the tick where counter reaches SERVE_FRAMES-1: counter cleared, go to PLAY.
- State PLAY, per tick:
  - Paddles:
    - up: y -= PADDLE_SPEED; down: y += PADDLE_SPEED.
    - Both or neither pressed: no change.
    - Clamp to [0, 480-PADDLE_H] (0..416); never wrap.
  - Vertical:
    - Moving up with ball_y < BALL_SPEED: ball_y=0, dir_y=+.
    - Moving down with ball_y+BALL_SPEED > 480-BALL_SIZE: ball_y=472, dir_y=-.
    - Otherwise ball_y ± BALL_SPEED.
  - Horizontal left:
    - Paddle hit requires ball_x >= P1_X+PADDLE_W (24), ball_x-BALL_SPEED <= 24, and vertical overlap (ball_y+BALL_SIZE > paddle_one_y and ball_y < paddle_one_y+PADDLE_H).
    - Hit: ball_x=24, dir_x=+.
    - Else if ball_x < BALL_SPEED: miss; player two scores.
  - Horizontal right:
    - Paddle hit requires ball_x+BALL_SIZE <= P2_X, ball_x+BALL_SIZE+BALL_SPEED >= P2_X, and overlap with paddle_two.
    - Hit: ball_x = P2_X-BALL_SIZE (608), dir_x=-.
    - Else if ball_x+BALL_SPEED > 640-BALL_SIZE: miss; player one scores.
  - Collision tests use pre-update paddle positions.
  - Vertical and horizontal resolution are independent; a corner hit flips both directions in the same tick.
  - The horizontal arithmetic in the left and right rules is done at 11 bits so it never underflows or overflows.
- Miss tick:
  - Scorer's score += 1.
  - Ball recentred (316,236); dir_x set toward the player who conceded; dir_y unchanged.
  - If the new score == WIN_SCORE: go to GAME_OVER; else go to SERVE with counter 0.
- State GAME_OVER:
  - game_over=1; ball at centre; paddles frozen; scores held.
  - On a tick with start=1: scores cleared, paddles to y=208, dir_x=+, go to SERVE.
  - start is ignored in other states.
- Mid-game reset restores all reset values on the next edge; no partial frame update occurs.

Test Plan:
1. Reset with endofframe held high, then release -> no update until endofframe falls and rises again; first tick leaves ball at (316,236) with state SERVE.
2. 60 ticks, no buttons -> ball starts moving at tick 61: ball_x 318, ball_y 238 one cycle after the tick.
3. Hold p1_up from y=4 for 2 ticks -> paddle_one_y 0 then 0. Press p1_up and p1_down together -> unchanged.
4. Force the ball to travel down into y=471 -> next tick ball_y=472 and dir_y flips, then ball_y=470 on the following tick.
5. Ball moving left at ball_x=25 with paddle_one_y=208, ball_y=240 -> ball_x=24, dir_x=+. Same with paddle_one_y=0, continued to ball_x=1 -> score_two=1, ball at (316,236), ball next moves left after the serve.
6. Preload score_one=6, then make paddle two miss -> score_one=7, game_over=1, outputs frozen. start=1 on the next tick -> scores 0, game_over=0, state SERVE.
